// File: rtl/kmeans_centroid_update.sv
// -----------------------------------------------------------------------------
// kmeans_centroid_update
//   Update half of a K-means iteration. Labelled samples are streamed in and
//   accumulated into per-cluster sums and counts. At the end of the batch each
//   sum is divided by its count with a sequential restoring divider. The
//   resulting centroids are emitted in index order 0..K-1 over a valid/ready
//   stream.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_start           one-cycle pulse in IDLE, begins a batch
//   i_in_valid/o_in_ready/i_in_data/i_in_label/i_in_last   sample stream
//   o_out_valid/i_out_ready/o_out_centroid/o_out_index/o_out_empty
//                     centroid stream; o_out_empty marks a cluster with no
//                     members (centroid forced to 0)
//   o_busy            high whenever the FSM is not idle
//   o_err             sticky for the batch: a sample was dropped because its
//                     label was out of range or the batch was already full
// -----------------------------------------------------------------------------
module kmeans_centroid_update #(
  parameter int DATA_W      = 8,
  parameter int K           = 2,
  parameter int MAX_SAMPLES = 8,
  localparam int LBL_W      = (K > 1) ? $clog2(K) : 1,
  localparam int CNT_W      = $clog2(MAX_SAMPLES + 1),
  localparam int SUM_W      = DATA_W + CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [LBL_W-1:0]  i_in_label,
  input  logic              i_in_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_centroid,
  output logic [LBL_W-1:0]  o_out_index,
  output logic              o_out_empty,
  output logic              o_busy,
  output logic              o_err
);

  localparam int ITER_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam logic [LBL_W:0]  K_EXT     = (LBL_W + 1)'(K);
  localparam logic [LBL_W-1:0] K_LAST   = LBL_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SAMPLES);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(SUM_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DIV   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SUM_W-1:0]  r_sum [K];
  logic [CNT_W-1:0]  r_cnt [K];
  logic [CNT_W-1:0]  r_total;
  logic [LBL_W-1:0]  r_k;
  logic              r_loaded;
  logic [ITER_W-1:0] r_iter;
  logic [SUM_W-1:0]  r_quot;
  logic [CNT_W-1:0]  r_rem;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_centroid;
  logic [LBL_W-1:0]  r_out_index;
  logic              r_out_empty;
  logic              r_busy;
  logic              r_err;

  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_label_ok;
  logic              w_room;
  logic              w_accept;
  logic              w_k_last;
  logic [CNT_W-1:0]  w_cnt_k;
  logic [SUM_W-1:0]  w_sum_k;
  logic              w_div_empty;
  logic              w_div_done;
  logic [CNT_W:0]    w_rem_sh;
  logic              w_ge;
  logic [CNT_W-1:0]  w_rem_sub;
  logic [CNT_W-1:0]  w_rem_nxt;
  logic [SUM_W-1:0]  w_quot_nxt;

  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_centroid = r_out_centroid;
  assign o_out_index    = r_out_index;
  assign o_out_empty    = r_out_empty;
  assign o_busy         = r_busy;
  assign o_err          = r_err;

  // Handshake qualifiers and the accept/drop decision for incoming samples.
  always_comb begin
    w_in_hs    = (r_state == ST_ACCUM) && r_in_ready && i_in_valid;
    w_out_hs   = (r_state == ST_OUT) && r_out_valid && i_out_ready;
    w_label_ok = ({1'b0, i_in_label} < K_EXT);
    w_room     = (r_total < CNT_MAX);
    w_accept   = w_in_hs && w_label_ok && w_room;
    w_k_last   = (r_k == K_LAST);
  end

  // Select the sum and count of the cluster currently being divided.
  always_comb begin
    w_cnt_k = '0;
    w_sum_k = '0;
    for (int i = 0; i < K; i++) begin
      w_cnt_k = w_cnt_k | ((r_k == LBL_W'(i)) ? r_cnt[i] : {CNT_W{1'b0}});
      w_sum_k = w_sum_k | ((r_k == LBL_W'(i)) ? r_sum[i] : {SUM_W{1'b0}});
    end
  end

  // One restoring-division step: the partial remainder never exceeds the
  // divisor, so after the trial subtraction it fits back into CNT_W bits.
  always_comb begin
    w_rem_sh    = {r_rem, r_quot[SUM_W-1]};
    w_ge        = (w_rem_sh >= {1'b0, w_cnt_k});
    w_rem_sub   = w_rem_sh[CNT_W-1:0] - w_cnt_k;
    w_rem_nxt   = w_ge ? w_rem_sub : w_rem_sh[CNT_W-1:0];
    w_quot_nxt  = {r_quot[SUM_W-2:0], w_ge};
    w_div_empty = (r_state == ST_DIV) && !r_loaded && (w_cnt_k == {CNT_W{1'b0}});
    w_div_done  = (r_state == ST_DIV) && r_loaded && (r_iter == ITER_LAST);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_in_hs && i_in_last) begin
          w_state_nxt = ST_DIV;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DIV: begin
        if (w_div_empty || w_div_done) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      ST_OUT: begin
        if (w_out_hs) begin
          w_state_nxt = w_k_last ? ST_IDLE : ST_DIV;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: accumulation, divider and registered stream outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < K; i++) begin
        r_sum[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_total        <= '0;
      r_k            <= '0;
      r_loaded       <= 1'b0;
      r_iter         <= '0;
      r_quot         <= '0;
      r_rem          <= '0;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_centroid <= '0;
      r_out_index    <= '0;
      r_out_empty    <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_ACCUM);
      r_busy     <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < K; i++) begin
              r_sum[i] <= '0;
              r_cnt[i] <= '0;
            end
            r_total  <= '0;
            r_k      <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            for (int i = 0; i < K; i++) begin
              if (i_in_label == LBL_W'(i)) begin
                r_sum[i] <= r_sum[i] + SUM_W'(i_in_data);
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
              end
            end
            r_total <= r_total + CNT_W'(1);
          end else if (w_in_hs) begin
            r_err <= 1'b1;
          end
        end
        ST_DIV: begin
          if (!r_loaded) begin
            if (w_div_empty) begin
              r_out_centroid <= '0;
              r_out_empty    <= 1'b1;
              r_out_index    <= r_k;
              r_out_valid    <= 1'b1;
            end else begin
              r_quot   <= w_sum_k;
              r_rem    <= '0;
              r_iter   <= '0;
              r_loaded <= 1'b1;
            end
          end else begin
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_iter <= r_iter + ITER_W'(1);
            if (w_div_done) begin
              // sum <= count * (2^DATA_W - 1), so the quotient fits DATA_W.
              r_out_centroid <= w_quot_nxt[DATA_W-1:0];
              r_out_empty    <= 1'b0;
              r_out_index    <= r_k;
              r_out_valid    <= 1'b1;
              r_loaded       <= 1'b0;
            end
          end
        end
        ST_OUT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            if (!w_k_last) begin
              r_k <= r_k + LBL_W'(1);
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/kmeans_centroid_update.md
Name: kmeans_centroid_update

Overview:
- Update half of the K-means loop: the assignment stage maps samples to cluster labels; this block maps (sample, label) pairs back to new centroid values.
- Streams in labelled samples, accumulates per-cluster sums and counts, then divides each sum by its count with a sequential restoring divider.
- Emits centroids one per cluster over a valid/ready output stream, ready to feed the next assignment pass.

Parameters:
- DATA_W, 8, sample and centroid width (unsigned).
- K, 2, number of clusters (2..8).
- MAX_SAMPLES, 8, maximum accepted samples per batch.
- LBL_W, derived = max(1, clog2(K)), label width.
- CNT_W, derived = clog2(MAX_SAMPLES+1), per-cluster count width.
- SUM_W, derived = DATA_W+CNT_W, per-cluster sum width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a batch
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid&&in_ready
- in_data  in  DATA_W  sample value
- in_label  in  LBL_W  cluster index of sample
- in_last  in  1  marks final sample of batch
- out_valid  out  1  centroid valid
- out_ready  in  1  consumer accepts centroid
- out_centroid  out  DATA_W  floor(sum/count) for cluster out_index
- out_index  out  LBL_W  cluster index of out_centroid
- out_empty  out  1  cluster had zero members; out_centroid=0
- busy  out  1  high in any state but IDLE
- err  out  1  sticky per batch: dropped sample (label>=K or overflow)

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, out_valid=0, out_centroid=0, out_index=0, out_empty=0, busy=0, err=0; all sums/counts cleared. Reset mid-batch or mid-divide abandons the batch entirely; no partial output is ever emitted.
- FSM states: IDLE, ACCUM, DIV, OUT.
- IDLE:
  - start=1 -> ACCUM next cycle.
  - On entry to ACCUM: sums/counts cleared, err cleared.
  - start is ignored in every other state.
- ACCUM:
  - in_ready=1.
  - On handshake, if label<K and total accepted<MAX_SAMPLES: sum[label]+=in_data, count[label]+=1.
  - Otherwise the sample is dropped and err is set.
  - A handshake with in_last=1 (whether the sample is used or dropped) -> DIV with k=0; in_ready drops the following cycle.
- DIV, per cluster k:
  - Nonempty cluster: 1 load cycle, then SUM_W restoring iterations, one quotient bit per cycle; SUM_W+1 cycles total.
  - Empty cluster (count=0): 1 cycle; quotient=0, out_empty=1, no division.
  - The quotient is truncated (floor) and always fits in DATA_W.
  - -> OUT.
- OUT:
  - out_valid=1; out_centroid, out_index and out_empty are held stable until out_ready.
  - On handshake: if k<K-1, k+=1 and go to DIV; else go to IDLE.
  - out_valid is low during DIV, so there is a gap between successive outputs.
- Latency: in_last handshake at cycle T, cluster 0 nonempty -> out_valid first high at T+SUM_W+2 (T+14 at defaults).
- Sum width SUM_W guarantees no sum overflow at MAX_SAMPLES of full-scale data.
- Clusters are always output in index order 0..K-1, each exactly once per batch.

Test Plan:
- Data {10,20,30,40,200,210,220,230}, labels {0,0,0,0,1,1,1,1}, in_last on 8th -> (idx0, 25, empty=0) then (idx1, 215, empty=0); first out_valid 14 cycles after last handshake; err=0.
- Data {1,2,7}, all label 0 -> idx0=3 (10/3 floor), idx1 centroid 0 with out_empty=1; idx1 out_valid appears 2 cycles after idx0 handshake.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid, out_centroid, out_index stable; on release, next cluster proceeds normally.
- Nine samples of 255, label 0, in_last on 9th -> 9th dropped, err=1, idx0=255, idx1 empty.
- K=2, sample {50, label 1} plus {60, label 0}, with an invalid label injected using K=3 build and label=3 -> invalid sample dropped, err=1, remaining centroids correct.
- Assert rst_n=0 mid-DIV -> all outputs 0 asynchronously, state IDLE; a new start gives a clean batch with no leftover sums.
